id_stage_pipe: RTL and testbench

Pipelined LEGv8 instruction-decode stage sitting between fetch and `Execution`. It accepts one fetched instruction per cycle over a valid/ready handshake. It decodes the opcode into the control bundle, reads the register file and sign-extends the immediate. It registers everything into an ID/EX pipeline register with its own valid/ready handshake. It owns the architectural register file, with the zero register hard-wired, takes writeback from a separate port, and detects load-use hazards, inserting one bubble per hazard.

---
 rtl/id_stage_pipe_if.sv | 32 +++
 rtl/id_stage_pipe.sv | 169 ++++++++++++++++
 tb/tb_id_stage_pipe.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// Fetch-side and execute-side handshake bundle for the LEGv8 decode stage.
// slave is the decode stage's view, master is the fetch/execute environment's.
interface id_stage_pipe_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rd;
    logic [9:0]        ex_ctrl;
    logic              ex_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready,
        output if_ready, ex_valid, ex_pc, ex_rd1, ex_rd2,
        output ex_imm, ex_rd, ex_ctrl, ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, ex_ready,
        input  if_ready, ex_valid, ex_pc, ex_rd1, ex_rd2,
        input  ex_imm, ex_rd, ex_ctrl, ex_illegal
    );
endinterface

// File: rtl/id_stage_pipe.sv
// LEGv8 decode stage: decode, register file, load-use stall, ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback to the read ports.
module id_stage_pipe #(
    parameter int         DATA_W   = 64,
    parameter int         ADDR_W   = 64,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic              clk,
    input  logic              rst_n,
    id_stage_pipe_if.slave    bus,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_d [32];

    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [9:0]        ex_ctrl_q, ex_ctrl_d;
    logic              ex_illegal_q, ex_illegal_d;

    logic [31:0]       ins;
    logic [10:0]       opc;
    logic              is_r, is_ld, is_st, is_cbz, is_cbnz, is_b;
    logic [9:0]        ctrl;
    logic              illegal;
    logic [DATA_W-1:0] imm;
    logic [4:0]        ra1, ra2;
    logic [DATA_W-1:0] rdat1, rdat2;
    logic              use1, use2, hazard, adv, accept;

    assign ins     = bus.if_instr;
    assign opc     = ins[31:21];
    assign is_r    = (opc == OP_ADD) || (opc == OP_SUB) ||
                     (opc == OP_AND) || (opc == OP_ORR);
    assign is_ld   = (opc == OP_LDUR);
    assign is_st   = (opc == OP_STUR);
    assign is_cbz  = (ins[31:24] == 8'b10110100);
    assign is_cbnz = (ins[31:24] == 8'b10110101);
    assign is_b    = (ins[31:26] == 6'b000101);

    // ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, B, CBZ, CBNZ, ALUOp}
    always_comb begin
        ctrl    = '0;
        imm     = '0;
        illegal = 1'b0;
        unique case (1'b1)
            is_r: ctrl = 10'b1000000010;
            is_ld: begin
                ctrl = 10'b1101100000;
                imm  = {{(DATA_W-9){ins[20]}}, ins[20:12]};
            end
            is_st: begin
                ctrl = 10'b0010100000;
                imm  = {{(DATA_W-9){ins[20]}}, ins[20:12]};
            end
            is_cbz: begin
                ctrl = 10'b0000001001;
                imm  = {{(DATA_W-21){ins[23]}}, ins[23:5], 2'b00};
            end
            is_cbnz: begin
                ctrl = 10'b0000000101;
                imm  = {{(DATA_W-21){ins[23]}}, ins[23:5], 2'b00};
            end
            is_b: begin
                ctrl = 10'b0000010000;
                imm  = {{(DATA_W-28){ins[25]}}, ins[25:0], 2'b00};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign ra1 = ins[9:5];
    assign ra2 = (is_st || is_cbz || is_cbnz) ? ins[4:0] : ins[20:16];

    always_comb begin
        rdat1 = rf_q[ra1];
        rdat2 = rf_q[ra2];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && (wb_addr == ra1)) rdat1 = wb_data;
        if (wb_en && (wb_addr == ra2)) rdat2 = wb_data;
`endif
        if (ra1 == ZERO_REG) rdat1 = '0;
        if (ra2 == ZERO_REG) rdat2 = '0;
    end

    assign use1   = !is_b;
    assign use2   = is_r || is_st || is_cbz || is_cbnz;
    assign hazard = ex_valid_q && ex_ctrl_q[8] && (ex_rd_q != ZERO_REG) &&
                    ((use1 && (ra1 == ex_rd_q)) || (use2 && (ra2 == ex_rd_q)));
    assign adv    = !ex_valid_q || bus.ex_ready;
    assign accept = rst_n && adv && !hazard && !flush;

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != ZERO_REG)) rf_d[wb_addr] = wb_data;
    end

    // A stalled cycle still loads the payload; only ex_valid marks the bubble.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_rd1_d     = ex_rd1_q;
        ex_rd2_d     = ex_rd2_q;
        ex_imm_d     = ex_imm_q;
        ex_rd_d      = ex_rd_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_illegal_d = ex_illegal_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (adv) begin
            ex_valid_d   = bus.if_valid && accept;
            ex_pc_d      = bus.if_pc;
            ex_rd1_d     = rdat1;
            ex_rd2_d     = rdat2;
            ex_imm_d     = imm;
            ex_rd_d      = ins[4:0];
            ex_ctrl_d    = ctrl;
            ex_illegal_d = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rd1_q     <= '0;
            ex_rd2_q     <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= '0;
            ex_illegal_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_rd1_q     <= ex_rd1_d;
            ex_rd2_q     <= ex_rd2_d;
            ex_imm_q     <= ex_imm_d;
            ex_rd_q      <= ex_rd_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_illegal_q <= ex_illegal_d;
        end
    end

    assign bus.if_ready   = accept;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_rd1     = ex_rd1_q;
    assign bus.ex_rd2     = ex_rd2_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_illegal = ex_illegal_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed LEGv8 vectors,
// monitor pops expected ID/EX contents whenever execute consumes one.
module tb_id_stage_pipe;
    typedef struct {
        logic [63:0] pc;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [9:0]  ctrl;
        logic        ill;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        wb_en = 0;
    logic [4:0]  wb_addr = 0;
    logic [63:0] wb_data = 0;
    logic [63:0] pc_n = 64'h1000;
    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];

    id_stage_pipe_if #(.DATA_W(64), .ADDR_W(64)) bus ();

    id_stage_pipe dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .flush  (flush),
        .wb_en  (wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [63:0] rd1, input logic [63:0] rd2,
                                input logic [63:0] imm, input logic [4:0] rd,
                                input logic [9:0] ctrl, input logic ill);
        exp_t e;
        e.pc = 0; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.rd = rd; e.ctrl = ctrl; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every consumed ID/EX entry must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ex_valid && bus.ex_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ex: pc=%h with empty scoreboard", bus.ex_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.ex_pc !== e.pc || bus.ex_rd1 !== e.rd1 ||
                    bus.ex_rd2 !== e.rd2 || bus.ex_rd !== e.rd ||
                    bus.ex_ctrl !== e.ctrl || bus.ex_illegal !== e.ill ||
                    (!e.ill && bus.ex_imm !== e.imm)) begin
                    fails++;
                    $display("FAIL ex_bundle pc=%h: got rd1=%h rd2=%h imm=%h rd=%0d ctrl=%b ill=%b, expected rd1=%h rd2=%h imm=%h rd=%0d ctrl=%b ill=%b",
                             e.pc, bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_rd,
                             bus.ex_ctrl, bus.ex_illegal, e.rd1, e.rd2, e.imm,
                             e.rd, e.ctrl, e.ill);
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins, input bit push, input exp_t e,
                        output int stalls, output logic v_acc);
        bus.if_valid = 1;
        bus.if_instr = ins;
        bus.if_pc    = pc_n;
        e.pc         = pc_n;
        if (push) q.push_back(e);
        stalls = 0;
        v_acc  = 0;
        forever begin
            @(negedge clk);
            if (bus.if_ready) break;
            stalls++;
            if (stalls > 20) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: instr %h not accepted, expected within 20 cycles", ins);
                break;
            end
        end
        v_acc = bus.ex_valid;
        @(posedge clk); #1;
        bus.if_valid = 0;
        pc_n += 4;
    endtask

    task automatic wb(input logic [4:0] a, input logic [63:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 0;
    endtask

    initial begin
        int   st;
        logic va;
        exp_t e;

        bus.if_valid = 1;
        bus.if_instr = 32'h8B020023;
        bus.if_pc    = 64'h40;
        bus.ex_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", {63'd0, bus.ex_valid}, 0);
        chk("rst_if_ready", {63'd0, bus.if_ready}, 0);
        chk("rst_ctrl", {54'd0, bus.ex_ctrl}, 0);
        chk("rst_ops", bus.ex_rd1 | bus.ex_rd2 | bus.ex_imm | bus.ex_pc, 0);
        chk("rst_rd_ill", {58'd0, bus.ex_rd, bus.ex_illegal}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        bus.if_valid = 0;

        // X0 / X31 read back as zero
        send(32'h8B1F0007, 1, mk(0, 0, 0, 7, 10'h202, 0), st, va);
        wb(1, 64'd5);
        wb(2, 64'd7);
        send(32'h8B020023, 1, mk(5, 7, 0, 3, 10'h202, 0), st, va);
        chk("add_no_stall", st, 0);

        // Load-use: LDUR X4,[X1,#-8] then ADD X5,X4,X2
        send(32'hF85F8024, 1, mk(5, 0, 64'hFFFF_FFFF_FFFF_FFF8, 4, 10'h360, 0), st, va);
        chk("ldur_no_stall", st, 0);
        send(32'h8B020085, 1, mk(0, 7, 0, 5, 10'h202, 0), st, va);
        chk("loaduse_stall_cycles", st, 1);
        chk("loaduse_bubble", {63'd0, va}, 0);

        send(32'hF8010022, 1, mk(5, 7, 16, 2, 10'h0A0, 0), st, va);
        chk("stur_after_add_no_stall", st, 0);
        send(32'h14000002, 1, mk(0, 0, 8, 2, 10'h010, 0), st, va);
        chk("b_back_to_back", st, 0);

        // Backpressure, then flush while stalled
        send(32'h8B020023, 0, mk(0, 0, 0, 0, 0, 0), st, va);
        bus.ex_ready = 0;
        bus.if_valid = 1;
        bus.if_instr = 32'hCB020028;
        bus.if_pc    = pc_n;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_if_ready", {63'd0, bus.if_ready}, 0);
            chk("bp_hold_rd1", bus.ex_rd1, 5);
            chk("bp_hold_rd", {59'd0, bus.ex_rd}, 3);
            @(posedge clk); #1;
        end
        flush = 1;
        @(negedge clk);
        chk("flush_if_ready", {63'd0, bus.if_ready}, 0);
        @(posedge clk); #1;
        flush = 0;
        bus.if_valid = 0;
        bus.ex_ready = 1;
        @(negedge clk);
        chk("flush_ex_valid", {63'd0, bus.ex_valid}, 0);
        @(posedge clk); #1;
        pc_n += 4;

        // Writeback in the same cycle as a CBZ reading X6
        wb(6, 64'h55);
        wb_en = 1; wb_addr = 6; wb_data = 64'h1234;
`ifdef ID_WB_BYPASS_EN
        e = mk(0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0, 6, 10'h009, 0);
`else
        e = mk(0, 64'h55, 64'hFFFF_FFFF_FFFF_FFF0, 6, 10'h009, 0);
`endif
        send(32'hB4FFFF86, 1, e, st, va);
        wb_en = 0;
        send(32'hB5FFFF86, 1, mk(0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0, 6, 10'h005, 0), st, va);

        // Zero register ignores writes; illegal opcode
        wb(31, 64'hFF);
        send(32'h8B1F03E9, 1, mk(0, 0, 0, 9, 10'h202, 0), st, va);
        send(32'hFFFFFFFF, 1, mk(0, 0, 0, 31, 10'h000, 1), st, va);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
